// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmit path.
//   state_t    - host-to-device transfer FSM states
//   err_code_t - abort reason reported on tx_err_code
//   CMD_* / RSP_* - common keyboard command and response bytes
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    REQ       = 3'd3,
    SHIFT     = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_START  = 2'b01,
    ERR_PACKET = 2'b10,
    ERR_NOACK  = 2'b11
  } err_code_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pad level.
//   clk, rst : system clock, synchronous active-low reset
//   raw      : asynchronous pad level
//   level    : filtered level (idle high)
//   fall     : one-cycle pulse when level goes 1 -> 0
// A new level is accepted only after FILTER_LEN consecutive synchronized
// samples disagree with the current one.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      fall   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      fall   <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync_2;
        cnt   <= '0;
        fall  <= level & ~sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from host to PS/2 device using the
// host-request sequence (inhibit clock, pull data, release clock, shift
// bits on device falling edges, sample the device ACK).
//   clk, rst                  : system clock, synchronous active-low reset
//   tx_data, tx_start         : byte and single-cycle request (ignored when busy)
//   tx_busy, rx_inhibit       : transfer in progress
//   tx_done, tx_err           : one-cycle completion / abort pulses
//   tx_err_code               : abort reason, held until the next abort
//   ps2_clk_in, ps2_data_in   : raw pad levels
//   ps2_clk_oe, ps2_data_oe   : 1 = pull pad low, 0 = release
//   dbg_state                 : current FSM state
// Handshake: tx_start is taken only in a cycle where tx_busy is 0; tx_busy
// rises the next cycle and falls in the same cycle as tx_done or tx_err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES   = 12000,
  parameter int START_TO_CYCLES  = 1500000,
  parameter int PACKET_TO_CYCLES = 200000,
  parameter int FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] tx_err_code,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output state_t     dbg_state
);

  localparam int T_MAX = (INHIBIT_CYCLES > START_TO_CYCLES) ? INHIBIT_CYCLES : START_TO_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int PW    = $clog2(PACKET_TO_CYCLES + 1);

  state_t    state;
  logic [TW-1:0] timer;
  logic [PW-1:0] pkt_timer;
  logic [3:0]    idx;
  logic [3:0]    idx_next;
  logic [9:0]    frame;
  logic          clk_level;
  logic          clk_fall;
  logic          data_level;
  logic          data_fall;
  logic          abort;
  err_code_t     abort_code;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_data_in),
    .level (data_level),
    .fall  (data_fall)
  );

  assign idx_next   = idx + 4'd1;
  assign rx_inhibit = tx_busy;
  assign dbg_state  = state;

  // Timeouts are checked first so they win over a same-cycle completion.
  always_comb begin
    abort      = 1'b0;
    abort_code = ERR_NONE;
    if (state == REQ && timer == TW'(START_TO_CYCLES - 1)) begin
      abort      = 1'b1;
      abort_code = ERR_START;
    end else if ((state == SHIFT || state == ACK || state == WAIT_IDLE) &&
                 pkt_timer == PW'(PACKET_TO_CYCLES - 1)) begin
      abort      = 1'b1;
      abort_code = ERR_PACKET;
    end else if (state == ACK && clk_fall && data_level) begin
      abort      = 1'b1;
      abort_code = ERR_NOACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      pkt_timer   <= '0;
      idx         <= '0;
      frame       <= '0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      tx_err_code <= ERR_NONE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        tx_busy     <= 1'b0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_err      <= 1'b1;
        tx_err_code <= abort_code;
      end else begin
        case (state)
          IDLE: begin
            if (tx_start) begin
              frame      <= {1'b1, odd_parity(tx_data), tx_data};
              timer      <= '0;
              tx_busy    <= 1'b1;
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (timer == TW'(INHIBIT_CYCLES - 1)) begin
              timer       <= '0;
              ps2_data_oe <= 1'b1;
              state       <= START;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          START: begin
            // Data is already low; releasing the clock now presents the start bit.
            ps2_clk_oe <= 1'b0;
            timer      <= '0;
            state      <= REQ;
          end
          REQ: begin
            timer <= timer + TW'(1);
            if (clk_fall) begin
              idx         <= '0;
              pkt_timer   <= '0;
              ps2_data_oe <= ~frame[0];
              state       <= SHIFT;
            end
          end
          SHIFT: begin
            pkt_timer <= pkt_timer + PW'(1);
            if (clk_fall) begin
              idx         <= idx_next;
              ps2_data_oe <= ~frame[idx_next];
              // Once the stop bit is on the line the next fall carries the ACK.
              if (idx == 4'd8) state <= ACK;
            end
          end
          ACK: begin
            pkt_timer <= pkt_timer + PW'(1);
            if (clk_fall) begin
              ps2_data_oe <= 1'b0;
              state       <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            pkt_timer <= pkt_timer + PW'(1);
            if (clk_level && data_level) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int STO = 500;
  localparam int PTO = 2000;
  localparam int FL  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic [1:0] tx_err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  state_t     dbg_state;

  // open-drain bus: device releases = 1, either side may pull low
  logic dev_clk_rel  = 1'b1;
  logic dev_data_rel = 1'b1;
  logic clk_line, data_line;
  assign clk_line  = ~ps2_clk_oe  & dev_clk_rel;
  assign data_line = ~ps2_data_oe & dev_data_rel;

  ps2_host_tx #(
    .INHIBIT_CYCLES  (INH),
    .START_TO_CYCLES (STO),
    .PACKET_TO_CYCLES(PTO),
    .FILTER_LEN      (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .tx_err_code(tx_err_code),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  logic [0:0] exp_q[$];
  logic [0:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
  end

  // device samples data on every rising edge of the bus clock
  always @(posedge clk_line) rx_q.push_back(data_line);

  // word bit i is the i-th bit seen by the device (start, d0..d7, parity, stop)
  task automatic check_frame(input string tag, input logic [10:0] word);
    logic [0:0] e, g;
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(word[i]);
    check({tag, "_len"}, 32'(rx_q.size() >= 11), 32'd1);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 1'bx;
      check($sformatf("%s_bit%0d", tag, i), 32'(g), 32'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  // returns at the negedge just after the accepting clock edge
  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    rx_q.delete();
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // device produces n clock pulses; ACK drives data low around pulse 11
  task automatic dev_run(input int n_pulses, input bit ack_low);
    repeat (60) @(negedge clk);
    for (int i = 1; i <= n_pulses; i++) begin
      if (i == 11 && ack_low) dev_data_rel = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk_rel = 1'b0;
      repeat (40) @(negedge clk);
      dev_clk_rel = 1'b1;
      if (i == 11) dev_data_rel = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_not_busy(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_tmo"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_err(input string tag, input int budget, output int n);
    n = 0;
    while (tx_err !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_err_seen"}, 32'(tx_err), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0, e0, n;

    repeat (4) @(negedge clk);
    check("rst_busy",  32'(tx_busy),     32'd0);
    check("rst_done",  32'(tx_done),     32'd0);
    check("rst_err",   32'(tx_err),      32'd0);
    check("rst_code",  32'(tx_err_code), 32'd0);
    check("rst_inh",   32'(rx_inhibit),  32'd0);
    check("rst_clkoe", 32'(ps2_clk_oe),  32'd0);
    check("rst_datoe", 32'(ps2_data_oe), 32'd0);
    check("rst_state", 32'(dbg_state),   32'(IDLE));
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // 0xED with request-sequence timing
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_SET_LED);
    check("ed_busy1",  32'(tx_busy),     32'd1);
    check("ed_inh1",   32'(rx_inhibit),  32'd1);
    check("ed_clkoe1", 32'(ps2_clk_oe),  32'd1);
    check("ed_datoe1", 32'(ps2_data_oe), 32'd0);
    repeat (19) @(negedge clk);
    check("ed_datoe19", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    check("ed_datoe20", 32'(ps2_data_oe), 32'd1);
    check("ed_clkoe20", 32'(ps2_clk_oe),  32'd1);
    @(negedge clk);
    check("ed_clkoe21", 32'(ps2_clk_oe),  32'd0);
    check("ed_datoe21", 32'(ps2_data_oe), 32'd1);
    check("ed_req",     32'(dbg_state),   32'(REQ));
    repeat (3) @(negedge clk);
    dev_run(11, 1'b1);
    wait_not_busy("ed", 500);
    repeat (5) @(negedge clk);
    check_frame("ed", 11'b1_1_11101101_0);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_err",  32'(err_cnt - e0),  32'd0);

    // 0xF4 with a stray tx_start while busy
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_ENABLE);
    repeat (5) @(negedge clk);
    tx_data = 8'h00; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (18) @(negedge clk);
    dev_run(11, 1'b1);
    wait_not_busy("f4", 500);
    repeat (30) @(negedge clk);
    check_frame("f4", 11'b1_0_11110100_0);
    check("f4_done",    32'(done_cnt - d0), 32'd1);
    check("f4_err",     32'(err_cnt - e0),  32'd0);
    check("f4_idle",    32'(tx_busy),       32'd0);

    // no ACK: data left high on the 11th fall
    d0 = done_cnt;
    start_tx(CMD_SET_LED);
    repeat (24) @(negedge clk);
    fork
      dev_run(11, 1'b0);
      wait_err("noack", 2000, n);
    join_any
    check("noack_code", 32'(tx_err_code), 32'(ERR_NOACK));
    check("noack_busy", 32'(tx_busy),     32'd0);
    wait fork;
    repeat (30) @(negedge clk);
    check("noack_done", 32'(done_cnt - d0), 32'd0);

    // packet timeout: device stops after 4 pulses
    start_tx(CMD_RESET);
    repeat (24) @(negedge clk);
    dev_run(4, 1'b0);
    wait_err("pkt", 3000, n);
    check("pkt_code",  32'(tx_err_code), 32'(ERR_PACKET));
    check("pkt_clkoe", 32'(ps2_clk_oe),  32'd0);
    check("pkt_datoe", 32'(ps2_data_oe), 32'd0);
    check("pkt_busy",  32'(tx_busy),     32'd0);
    repeat (20) @(negedge clk);

    // 0xFF completes normally after the timeout
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_RESET);
    repeat (24) @(negedge clk);
    dev_run(11, 1'b1);
    wait_not_busy("ff", 500);
    repeat (5) @(negedge clk);
    check_frame("ff", 11'b1_1_11111111_0);
    check("ff_done",     32'(done_cnt - d0), 32'd1);
    check("ff_err",      32'(err_cnt - e0),  32'd0);
    check("ff_codehold", 32'(tx_err_code),   32'(ERR_PACKET));

    // start timeout: device never clocks
    start_tx(CMD_ENABLE);
    n = 0;
    while (dbg_state != REQ && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sto_req", 32'(dbg_state), 32'(REQ));
    wait_err("sto", 1000, n);
    check("sto_delay", 32'(n),           32'd500);
    check("sto_code",  32'(tx_err_code), 32'(ERR_START));
    check("sto_clkoe", 32'(ps2_clk_oe),  32'd0);
    check("sto_datoe", 32'(ps2_data_oe), 32'd0);
    check("sto_busy",  32'(tx_busy),     32'd0);
    repeat (20) @(negedge clk);

    // reset in the middle of SHIFT
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_SET_LED);
    repeat (24) @(negedge clk);
    dev_run(3, 1'b0);
    check("mid_shift", 32'(dbg_state), 32'(SHIFT));
    rst = 1'b0;
    @(negedge clk);
    check("mid_busy",  32'(tx_busy),     32'd0);
    check("mid_clkoe", 32'(ps2_clk_oe),  32'd0);
    check("mid_datoe", 32'(ps2_data_oe), 32'd0);
    check("mid_err",   32'(tx_err),      32'd0);
    check("mid_code",  32'(tx_err_code), 32'd0);
    check("mid_state", 32'(dbg_state),   32'(IDLE));
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_errcnt",  32'(err_cnt - e0),  32'd0);
    check("mid_donecnt", 32'(done_cnt - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
